// File: rtl/sel_demux_if.sv
// Handshake and lane bus for sel_demux_router. The err_cnt signal exists only
// when SEL_ERR_CNT_EN is defined.
interface sel_demux_if;
  logic       in_valid;
  logic       in_ready;
  logic [3:0] in_sel;
  logic [3:0] in_data;
  logic [3:0] a, b, d, e;
  logic       a_vld, b_vld, d_vld, e_vld;
  logic       a_ack, b_ack, d_ack, e_ack;
  logic       err_clr;
  logic       err;
`ifdef SEL_ERR_CNT_EN
  logic [7:0] err_cnt;
`endif

  // Producer/consumer side.
  modport master (
    output in_valid, in_sel, in_data, a_ack, b_ack, d_ack, e_ack, err_clr,
    input  in_ready, a, b, d, e, a_vld, b_vld, d_vld, e_vld,
`ifdef SEL_ERR_CNT_EN
    input  err_cnt,
`endif
    input  err
  );

  // The router itself.
  modport slave (
    input  in_valid, in_sel, in_data, a_ack, b_ack, d_ack, e_ack, err_clr,
    output in_ready, a, b, d, e, a_vld, b_vld, d_vld, e_vld,
`ifdef SEL_ERR_CNT_EN
    output err_cnt,
`endif
    output err
  );
endinterface

// File: rtl/sel_demux_router.sv
// Lane-select demultiplexer feeding the four lanes read by the circuit5 mux.
// Optional macro SEL_ERR_CNT_EN adds the 8-bit saturating invalid-select counter.
module sel_demux_router #(
  parameter logic [3:0] RST_VAL = 4'hF
) (
  input logic         clk,
  input logic         areset,
  sel_demux_if.slave  bus
);

  localparam int unsigned NUM_LANES = 4;

  // Lane index follows the select code: 0=b, 1=e, 2=a, 3=d.
  logic [3:0]           lane_data [NUM_LANES];
  logic [NUM_LANES-1:0] lane_vld;
  logic [NUM_LANES-1:0] lane_ack;
  logic [NUM_LANES-1:0] lane_free;
  logic [NUM_LANES-1:0] lane_load;
  logic                 sel_ok;
  logic [1:0]           sel_idx;
  logic                 in_ready;
  logic                 accept;
  logic                 bad_accept;
  logic                 err_q;

  assign sel_ok    = (bus.in_sel[3:2] == 2'b00);
  assign sel_idx   = bus.in_sel[1:0];
  assign lane_ack  = {bus.d_ack, bus.a_ack, bus.e_ack, bus.b_ack};
  assign lane_free = ~lane_vld | lane_ack;

  // Invalid selects are always consumable so a bad code can never stall the producer.
  always_comb begin
    // NOTE: every always_comb output gets a default first so no latch is inferred.
    in_ready = 1'b1;
    if (sel_ok) in_ready = lane_free[sel_idx];
  end

  assign accept     = bus.in_valid & in_ready;
  assign bad_accept = accept & ~sel_ok;

  always_comb begin
    lane_load = '0;
    if (accept && sel_ok) lane_load[sel_idx] = 1'b1;
  end

  always_ff @(posedge clk or posedge areset) begin
    if (areset) begin
      // NOTE: the lane registers are real state the mux reads, so unlike a RAM they are reset.
      for (int i = 0; i < NUM_LANES; i++) lane_data[i] <= RST_VAL;
      lane_vld <= '0;
    end else begin
      for (int i = 0; i < NUM_LANES; i++) begin
        // NOTE: non-blocking assignments keep every register sampling pre-edge values.
        if (lane_load[i]) begin
          lane_data[i] <= bus.in_data;
          lane_vld[i]  <= 1'b1;
        end else if (lane_ack[i]) begin
          lane_vld[i]  <= 1'b0;
        end
      end
    end
  end

  // A same-cycle invalid accept takes priority over err_clr.
  always_ff @(posedge clk or posedge areset) begin
    if (areset)            err_q <= 1'b0;
    else if (bad_accept)   err_q <= 1'b1;
    else if (bus.err_clr)  err_q <= 1'b0;
  end

`ifdef SEL_ERR_CNT_EN
  logic [7:0] err_cnt_q;

  always_ff @(posedge clk or posedge areset) begin
    if (areset) begin
      err_cnt_q <= 8'h00;
    end else if (bad_accept) begin
      if (bus.err_clr)             err_cnt_q <= 8'h01;
      else if (err_cnt_q != 8'hFF) err_cnt_q <= err_cnt_q + 8'h01;
    end else if (bus.err_clr) begin
      err_cnt_q <= 8'h00;
    end
  end

  assign bus.err_cnt = err_cnt_q;
`endif

  assign bus.in_ready = in_ready;
  assign bus.err      = err_q;
  assign bus.b        = lane_data[0];
  assign bus.e        = lane_data[1];
  assign bus.a        = lane_data[2];
  assign bus.d        = lane_data[3];
  assign bus.b_vld    = lane_vld[0];
  assign bus.e_vld    = lane_vld[1];
  assign bus.a_vld    = lane_vld[2];
  assign bus.d_vld    = lane_vld[3];

endmodule
